// File: rtl/clint_pkg.sv
// clint_pkg: register offsets, reset values, register-file type and byte-merge helper for the clint
package clint_pkg;
  localparam logic [31:0] clint_msip_off = 32'h0000_0000;
  localparam logic [31:0] clint_mtimecmp_off = 32'h0000_4000;
  localparam logic [31:0] clint_mtime_off = 32'h0000_BFF8;
  localparam logic [63:0] clint_mtimecmp_rst = 64'hFFFF_FFFF_FFFF_FFFF;
  typedef enum logic {IDLE, RESP} clint_state_e;
  typedef struct packed {
    clint_state_e state;
    logic msip;
    logic mtip;
    logic [63:0] mtimecmp;
    logic [31:0] rdata;
  } clint_reg_type;
  function automatic logic [31:0] merge_bytes(input logic [31:0] old, input logic [31:0] wdata, input logic [3:0] wstrb);
    merge_bytes = old;
    for (int i = 0; i < 4; i++) if (wstrb[i]) merge_bytes[8*i +: 8] = wdata[8*i +: 8];
  endfunction
endpackage

// File: rtl/clint_timer.sv
// clint_timer: prescaler plus 64-bit mtime counter; a write to either half preempts that cycle's increment
module clint_timer import clint_pkg::*; #(
  parameter int unsigned CLK_DIVIDER = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_lo_i,
  input  logic        we_hi_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  wstrb_i,
  output logic        tick_o,
  output logic [63:0] mtime_d_o,
  output logic [63:0] mtime_o
);
  logic [15:0] prescaler_q, prescaler_d;
  logic [63:0] mtime_q;
  always_comb begin
    tick_o = prescaler_q == 16'(CLK_DIVIDER - 1);
    prescaler_d = tick_o ? '0 : prescaler_q + 16'd1;
    mtime_d_o = we_lo_i ? {mtime_q[63:32], merge_bytes(mtime_q[31:0], wdata_i, wstrb_i)} :
                we_hi_i ? {merge_bytes(mtime_q[63:32], wdata_i, wstrb_i), mtime_q[31:0]} :
                tick_o  ? mtime_q + 64'd1 : mtime_q;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      prescaler_q <= '0;
      mtime_q <= '0;
    end else begin
      prescaler_q <= prescaler_d;
      mtime_q <= mtime_d_o;
    end
  end
  assign mtime_o = mtime_q;
endmodule

// File: rtl/clint.sv
// clint: memory-mapped msip/mtimecmp/mtime with single-cycle valid/ready response and registered mtip
module clint import clint_pkg::*; #(
  parameter int unsigned CLK_DIVIDER = 1,
  parameter logic [31:0] ADDR_MASK = 32'h0000_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clint_valid,
  input  logic        clint_instr,
  input  logic [31:0] clint_addr,
  input  logic [31:0] clint_wdata,
  input  logic [3:0]  clint_wstrb,
  output logic [31:0] clint_rdata,
  output logic        clint_ready,
  output logic        clint_msip,
  output logic        clint_mtip,
  output logic [63:0] clint_mtime
);
  clint_reg_type r_q, r_d;
  logic [31:0] off;
  logic req, wr, tick;
  logic sel_msip, sel_cmp_lo, sel_cmp_hi, sel_time_lo, sel_time_hi;
  logic [63:0] mtime_q, mtime_d;
  always_comb begin
    off = clint_addr & ADDR_MASK & ~32'h3;
    req = clint_valid && !clint_instr;
    wr = req && |clint_wstrb;
    sel_msip = off == clint_msip_off;
    sel_cmp_lo = off == clint_mtimecmp_off;
    sel_cmp_hi = off == clint_mtimecmp_off + 32'h4;
    sel_time_lo = off == clint_mtime_off;
    sel_time_hi = off == clint_mtime_off + 32'h4;
  end
  clint_timer #(.CLK_DIVIDER(CLK_DIVIDER)) u_timer (
    .clk(clk),
    .rst(rst),
    .we_lo_i(wr && sel_time_lo),
    .we_hi_i(wr && sel_time_hi),
    .wdata_i(clint_wdata),
    .wstrb_i(clint_wstrb),
    .tick_o(tick),
    .mtime_d_o(mtime_d),
    .mtime_o(mtime_q)
  );
  always_comb begin
    r_d = r_q;
    r_d.state = clint_valid ? RESP : IDLE;
    r_d.msip = wr && sel_msip && clint_wstrb[0] ? clint_wdata[0] : r_q.msip;
    r_d.mtimecmp[31:0] = wr && sel_cmp_lo ? merge_bytes(r_q.mtimecmp[31:0], clint_wdata, clint_wstrb) : r_q.mtimecmp[31:0];
    r_d.mtimecmp[63:32] = wr && sel_cmp_hi ? merge_bytes(r_q.mtimecmp[63:32], clint_wdata, clint_wstrb) : r_q.mtimecmp[63:32];
    r_d.rdata = !req ? '0 :
                sel_msip ? {31'd0, r_q.msip} :
                sel_cmp_lo ? r_q.mtimecmp[31:0] :
                sel_cmp_hi ? r_q.mtimecmp[63:32] :
                sel_time_lo ? mtime_q[31:0] :
                sel_time_hi ? mtime_q[63:32] : '0;
    // operands only move on a tick or a write, so the compare result is otherwise unchanged
    r_d.mtip = tick || wr ? mtime_d >= r_d.mtimecmp : r_q.mtip;
  end
  always_ff @(posedge clk) begin
    if (!rst) r_q <= '{state: IDLE, msip: 1'b0, mtip: 1'b0, mtimecmp: clint_mtimecmp_rst, rdata: '0};
    else r_q <= r_d;
  end
  assign clint_ready = r_q.state == RESP;
  assign clint_rdata = r_q.rdata;
  assign clint_msip = r_q.msip;
  assign clint_mtip = r_q.mtip;
  assign clint_mtime = mtime_q;
endmodule

// File: tb/tb_clint.sv
// tb_clint: directed table-driven and sequence checks of clint at CLK_DIVIDER 1 and 4
module tb_clint;
  logic clk = 0, rst = 0, valid = 0, instr = 0;
  logic [31:0] addr = 0, wdata = 0;
  logic [3:0] wstrb = 0;
  logic [31:0] rdata1, rdata4;
  logic ready1, ready4, msip1, msip4, mtip1, mtip4;
  logic [63:0] mtime1, mtime4;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  clint #(.CLK_DIVIDER(1)) u_d1 (.clk(clk), .rst(rst), .clint_valid(valid), .clint_instr(instr), .clint_addr(addr),
    .clint_wdata(wdata), .clint_wstrb(wstrb), .clint_rdata(rdata1), .clint_ready(ready1), .clint_msip(msip1),
    .clint_mtip(mtip1), .clint_mtime(mtime1));
  clint #(.CLK_DIVIDER(4)) u_d4 (.clk(clk), .rst(rst), .clint_valid(valid), .clint_instr(instr), .clint_addr(addr),
    .clint_wdata(wdata), .clint_wstrb(wstrb), .clint_rdata(rdata4), .clint_ready(ready4), .clint_msip(msip4),
    .clint_mtip(mtip4), .clint_mtime(mtime4));
  typedef struct {
    logic instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0] wstrb;
    logic chk_rd;
    logic [31:0] exp_rdata;
    logic exp_msip;
  } vec_t;
  vec_t vecs [19];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic drive(input logic v, input logic ins, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    valid = v; instr = ins; addr = a; wdata = d; wstrb = s;
  endtask
  task automatic req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    drive(1, 0, a, d, s);
    @(negedge clk);
    drive(0, 0, 0, 0, 0);
  endtask
  task automatic do_reset();
    drive(0, 0, 0, 0, 0);
    rst = 0;
    repeat (2) @(negedge clk);
    rst = 1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    bit found;
    vecs = '{
      '{0, 32'h0000_0000, 32'h0, 4'h0, 1, 32'h0, 0},
      '{0, 32'h0000_0000, 32'hFFFF_FFFF, 4'b0001, 0, 32'h0, 1},
      '{0, 32'h0000_0000, 32'h0, 4'h0, 1, 32'h1, 1},
      '{0, 32'h0000_0000, 32'h0, 4'b0010, 0, 32'h0, 1},
      '{0, 32'h0000_0000, 32'h0, 4'h0, 1, 32'h1, 1},
      '{0, 32'h0000_4000, 32'h0, 4'h0, 1, 32'hFFFF_FFFF, 1},
      '{0, 32'h0000_4000, 32'h1234_5678, 4'b0011, 0, 32'h0, 1},
      '{0, 32'h0000_4000, 32'h0, 4'h0, 1, 32'hFFFF_5678, 1},
      '{0, 32'h0000_4002, 32'h0, 4'h0, 1, 32'hFFFF_5678, 1},
      '{0, 32'h0000_4004, 32'hAABB_CCDD, 4'b1100, 0, 32'h0, 1},
      '{0, 32'h0000_4004, 32'h0, 4'h0, 1, 32'hAABB_FFFF, 1},
      '{0, 32'h0000_1234, 32'hDEAD_BEEF, 4'hF, 0, 32'h0, 1},
      '{0, 32'h0000_1234, 32'h0, 4'h0, 1, 32'h0, 1},
      '{0, 32'h0001_0000, 32'h0, 4'h0, 1, 32'h1, 1},
      '{1, 32'h0000_0000, 32'h0, 4'h0, 1, 32'h0, 1},
      '{1, 32'h0000_4000, 32'h0, 4'hF, 0, 32'h0, 1},
      '{0, 32'h0000_4000, 32'h0, 4'h0, 1, 32'hFFFF_5678, 1},
      '{0, 32'h0000_0003, 32'h0, 4'b0001, 0, 32'h0, 0},
      '{0, 32'h0000_0000, 32'h0, 4'h0, 1, 32'h0, 0}
    };
    // reset state and free-running count at both dividers
    drive(0, 0, 0, 0, 0);
    rst = 0;
    repeat (2) @(negedge clk);
    chk("rst_mtime", mtime1, 64'h0);
    chk("rst_mtime4", mtime4, 64'h0);
    chk("rst_mtip", mtip1, 0);
    chk("rst_msip", msip1, 0);
    chk("rst_ready", ready1, 0);
    chk("rst_rdata", rdata1, 0);
    rst = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_ready", ready1, 0);
    end
    chk("idle_mtime1", mtime1, 64'd10);
    chk("idle_mtime4", mtime4, 64'd2);
    chk("idle_mtip", mtip1, 0);
    // divided counter after an mtime load
    do_reset();
    req(32'hBFF8, 32'd5, 4'hF);
    req(32'hBFFC, 32'd0, 4'hF);
    repeat (8) @(negedge clk);
    chk("div4_mtime", mtime4, 64'd7);
    chk("div4_pre_ready", ready4, 0);
    req(32'hBFF8, 32'h0, 4'h0);
    chk("div4_ready", ready4, 1);
    chk("div4_rdata", rdata4, 32'd7);
    // register map table
    do_reset();
    for (int i = 0; i < 19; i++) begin
      chk($sformatf("vec%0d_idle", i), ready1, 0);
      drive(1, vecs[i].instr, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb);
      @(negedge clk);
      chk($sformatf("vec%0d_ready", i), ready1, 1);
      chk($sformatf("vec%0d_msip", i), msip1, vecs[i].exp_msip);
      if (vecs[i].chk_rd) chk($sformatf("vec%0d_rdata", i), rdata1, vecs[i].exp_rdata);
      drive(0, 0, 0, 0, 0);
      @(negedge clk);
      chk($sformatf("vec%0d_rdata_idle", i), rdata1, 0);
    end
    // mtip rise on equality and clear on mtimecmp write
    do_reset();
    req(32'hBFF8, 32'h10, 4'hF);
    chk("cmp_start", mtime1, 64'h10);
    req(32'h4004, 32'h0, 4'hF);
    req(32'h4000, 32'h20, 4'hF);
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (mtime1 == 64'h20) begin
        found = 1;
        chk("mtip_rise", mtip1, 1);
      end else chk("mtip_low", mtip1, 0);
    end
    chk("mtip_reached", found, 1);
    req(32'h4000, 32'h0, 4'h0);
    chk("cmp_rd", rdata1, 32'h20);
    chk("mtip_after_rd", mtip1, 1);
    req(32'h4004, 32'h1, 4'hF);
    chk("mtip_clear", mtip1, 0);
    // carry, wrap and a partial write in a tick cycle
    do_reset();
    req(32'hBFF8, 32'hFFFF_FFFF, 4'hF);
    chk("carry_pre", mtime1, 64'h0000_0000_FFFF_FFFF);
    @(negedge clk);
    chk("carry", mtime1, 64'h1_0000_0000);
    req(32'h4000, 32'h0, 4'hF);
    req(32'h4004, 32'h0, 4'hF);
    req(32'hBFF8, 32'hFFFF_FFFF, 4'hF);
    req(32'hBFFC, 32'hFFFF_FFFF, 4'hF);
    chk("ones", mtime1, 64'hFFFF_FFFF_FFFF_FFFF);
    @(negedge clk);
    chk("wrap", mtime1, 64'h0);
    chk("wrap_mtip", mtip1, 1);
    req(32'hBFF8, 32'h1234_56AB, 4'b0001);
    chk("tick_wr", mtime1, 64'hAB);
    @(negedge clk);
    chk("tick_wr_next", mtime1, 64'hAC);
    // back-to-back requests
    do_reset();
    repeat (5) @(negedge clk);
    drive(1, 0, 32'hBFF8, 0, 0);
    @(negedge clk);
    chk("b2b0_ready", ready1, 1);
    chk("b2b0_rdata", rdata1, 32'd5);
    drive(1, 0, 32'h1234, 0, 0);
    @(negedge clk);
    chk("b2b1_ready", ready1, 1);
    chk("b2b1_rdata", rdata1, 32'h0);
    drive(1, 0, 32'h4000, 0, 0);
    @(negedge clk);
    chk("b2b2_ready", ready1, 1);
    chk("b2b2_rdata", rdata1, 32'hFFFF_FFFF);
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("b2b_end_ready", ready1, 0);
    chk("b2b_end_rdata", rdata1, 0);
    // reset in the middle of a back-to-back burst
    do_reset();
    req(32'h0000, 32'h1, 4'b0001);
    chk("rm_msip_set", msip1, 1);
    req(32'h4004, 32'h55, 4'hF);
    repeat (3) @(negedge clk);
    drive(1, 0, 32'hBFF8, 0, 0);
    @(negedge clk);
    chk("rm_ready0", ready1, 1);
    chk("rm_rdata0", rdata1, 32'd5);
    drive(1, 0, 32'h1234, 0, 0);
    rst = 0;
    @(negedge clk);
    chk("rm_ready", ready1, 0);
    chk("rm_rdata", rdata1, 0);
    chk("rm_mtime", mtime1, 64'h0);
    chk("rm_mtime4", mtime4, 64'h0);
    chk("rm_msip", msip1, 0);
    chk("rm_mtip", mtip1, 0);
    rst = 1;
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("rm_after_ready", ready1, 0);
    chk("rm_after_mtime", mtime1, 64'd1);
    req(32'h4004, 32'h0, 4'h0);
    chk("rm_cmp_hi", rdata1, 32'hFFFF_FFFF);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
